// File: rtl/audio_channel.sv
// DMA-fed stereo playback voice: fetches 32-bit L/R words into a FIFO
// and emits one stereo sample per rising edge of the output-rate tick.
//
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_dma_setup_request/count/address  start (or restart) a transfer
//   o_dma_request/address, i_dma_ready/rdata  DMA read handshake
//   o_busy                      transfer or buffered playback pending
//   i_output_sample_clock       output-rate tick (level, edge-detected)
//   o_output_sample_left/right  current signed stereo sample
module audio_channel #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dma_setup_request,
  input  logic [31:0] i_dma_setup_count,
  input  logic [31:0] i_dma_setup_address,
  output logic        o_dma_request,
  output logic [31:0] o_dma_address,
  input  logic        i_dma_ready,
  input  logic [31:0] i_dma_rdata,
  output logic        o_busy,
  input  logic        i_output_sample_clock,
  output logic [15:0] o_output_sample_left,
  output logic [15:0] o_output_sample_right
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [31:0] mem_q [FIFO_DEPTH];

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] occ;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        tick_prev_q;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;

  logic        tick;
  logic        push;
  logic        pop;
  logic [31:0] head;

  // Extra pointer bit distinguishes full from empty.
  assign occ  = wr_q - rd_q;
  assign tick = i_output_sample_clock & ~tick_prev_q;
  // A setup strobe discards any read completing in the same cycle.
  assign push = req_q & i_dma_ready & ~i_dma_setup_request;
  assign pop  = tick & (occ != '0);
  assign head = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    req_d   = req_q;
    left_d  = left_q;
    right_d = right_q;

    if (tick) begin
      if (pop) begin
        left_d  = head[15:0];
        right_d = head[31:16];
      end else begin
        left_d  = '0;
        right_d = '0;
      end
    end

    if (i_dma_setup_request) begin
      wr_d   = '0;
      rd_d   = '0;
      addr_d = i_dma_setup_address;
      rem_d  = i_dma_setup_count;
      req_d  = 1'b0;
    end else begin
      if (pop) rd_d = rd_q + 1'b1;
      if (push) begin
        wr_d   = wr_q + 1'b1;
        addr_d = addr_q + 32'd4;
        rem_d  = rem_q - 32'd1;
        // Low for one cycle so the arbiter cannot reissue this read.
        req_d  = 1'b0;
      end else if (!req_q && rem_q != '0 && occ != FULL) begin
        req_d = 1'b1;
      end
    end

    busy_d = (rem_d != '0) || (wr_d != rd_d) || req_d;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      tick_prev_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      tick_prev_q <= i_output_sample_clock;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= i_dma_rdata;
  end

  assign o_dma_request         = req_q;
  assign o_dma_address         = addr_q;
  assign o_busy                = busy_q;
  assign o_output_sample_left  = left_q;
  assign o_output_sample_right = right_q;

endmodule

// File: tb/tb_audio_channel.sv
// Self-checking bench for audio_channel against a queue-based
// behavioural model of the playback voice.
module tb_audio_channel;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        setup = 1'b0;
  logic [31:0] setup_cnt = '0;
  logic [31:0] setup_addr = '0;
  logic        req;
  logic [31:0] req_addr;
  logic        ready = 1'b0;
  logic [31:0] rdata = '0;
  logic        busy;
  logic        tick = 1'b0;
  logic [15:0] out_l;
  logic [15:0] out_r;

  audio_channel #(.FIFO_DEPTH(16)) dut (
    .i_clock               (clk),
    .i_reset               (i_reset),
    .i_dma_setup_request   (setup),
    .i_dma_setup_count     (setup_cnt),
    .i_dma_setup_address   (setup_addr),
    .o_dma_request         (req),
    .o_dma_address         (req_addr),
    .i_dma_ready           (ready),
    .i_dma_rdata           (rdata),
    .o_busy                (busy),
    .i_output_sample_clock (tick),
    .o_output_sample_left  (out_l),
    .o_output_sample_right (out_r)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_q [$];
  logic [31:0] dq [$];
  logic [31:0] alist [$];
  logic [31:0] wlist [$];
  logic [31:0] m_rem = '0;
  logic [31:0] m_addr = '0;
  logic [15:0] m_l = '0;
  logic [15:0] m_r = '0;
  logic        m_prev = 1'b0;
  logic        auto_rdy = 1'b1;
  int          nreads = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    logic        rdy;
    logic        tk;
    logic        su;
    logic        rst;
    logic [31:0] wd;
    logic [31:0] w;
    rdy = ready;
    tk  = tick;
    su  = setup;
    rst = i_reset;
    wd  = rdata;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_rem  = '0;
      m_addr = '0;
      m_l    = '0;
      m_r    = '0;
      m_prev = 1'b0;
    end else begin
      if (tk && !m_prev) begin
        if (m_q.size() > 0) begin
          w   = m_q.pop_front();
          m_l = w[15:0];
          m_r = w[31:16];
        end else begin
          m_l = '0;
          m_r = '0;
        end
      end
      m_prev = tk;
      if (su) begin
        m_q.delete();
        m_rem  = setup_cnt;
        m_addr = setup_addr;
      end else if (rdy) begin
        m_q.push_back(wd);
        alist.push_back(m_addr);
        wlist.push_back(wd);
        m_rem  = m_rem - 1;
        m_addr = m_addr + 4;
        nreads++;
      end
    end
    #1;
    chk("left", {16'h0, out_l}, {16'h0, m_l});
    chk("right", {16'h0, out_r}, {16'h0, m_r});
    chk("busy", {31'h0, busy},
        {31'h0, (m_rem != 0) || (m_q.size() != 0)});
    if (rst || su || rdy) chk("req_low", {31'h0, req}, 32'h0);
    if (req) begin
      chk("addr", req_addr, m_addr);
      chk("room", {31'h0, m_q.size() < 16}, 32'h1);
    end
    setup = 1'b0;
    ready = auto_rdy && req && !i_reset;
    if (ready) rdata = (dq.size() > 0) ? dq.pop_front() : $urandom;
  endtask

  task automatic do_setup(logic [31:0] a, logic [31:0] c);
    setup      = 1'b1;
    setup_addr = a;
    setup_cnt  = c;
    clk1();
  endtask

  task automatic pulse();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    clk1();
  endtask

  logic [15:0] exp_l [4] = '{16'hFFFF, 16'h0002, 16'h8000, 16'h0000};
  logic [15:0] exp_r [4] = '{16'h0001, 16'h0002, 16'h7FFF, 16'h0000};

  initial begin
    // 1: reset and idle, ticks on an empty channel
    repeat (3) clk1();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", req_addr, 32'h0);
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 4) == 1;
      clk1();
    end
    tick = 1'b0;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_l", {16'h0, out_l}, 32'h0);

    // 2: three-word transfer
    dq = '{32'h0001FFFF, 32'h00020002, 32'h7FFF8000};
    alist.delete();
    nreads = 0;
    do_setup(32'h1000, 32'd3);
    chk("busy_up", {31'h0, busy}, 32'h1);
    repeat (12) clk1();
    chk("n_reads3", nreads, 3);
    chk("a0", alist[0], 32'h1000);
    chk("a1", alist[1], 32'h1004);
    chk("a2", alist[2], 32'h1008);
    chk("no_req", {31'h0, req}, 32'h0);

    // 3: play out, then underrun
    for (int k = 0; k < 4; k++) begin
      tick = 1'b1;
      clk1();
      chk("play_l", {16'h0, out_l}, {16'h0, exp_l[k]});
      chk("play_r", {16'h0, out_r}, {16'h0, exp_r[k]});
      if (k == 2) chk("busy_end", {31'h0, busy}, 32'h0);
      tick = 1'b0;
      clk1();
    end

    // 4: FIFO fills, one tick frees one slot
    nreads = 0;
    do_setup($urandom, 32'd40);
    repeat (80) clk1();
    chk("fill16", nreads, 16);
    chk("fill_req", {31'h0, req}, 32'h0);
    pulse();
    repeat (10) clk1();
    chk("refill", nreads, 17);

    // 5: restart mid-transfer
    nreads = 0;
    do_setup(32'hFFFF_FFF8, 32'd10);
    for (int i = 0; i < 20 && nreads < 2; i++) clk1();
    chk("wait2", {31'h0, nreads >= 2}, 32'h1);
    nreads = 0;
    alist.delete();
    wlist.delete();
    do_setup(32'h2000, 32'd1);
    repeat (10) clk1();
    chk("restart_n", nreads, 1);
    chk("restart_a", alist[0], 32'h2000);
    pulse();
    chk("new_l", {16'h0, out_l}, {16'h0, wlist[0][15:0]});
    chk("new_r", {16'h0, out_r}, {16'h0, wlist[0][31:16]});

    // 6: held tick pops once; reset kills an outstanding request
    wlist.delete();
    do_setup(32'h3000, 32'd40);
    repeat (80) clk1();
    tick = 1'b1;
    repeat (5) clk1();
    tick = 1'b0;
    clk1();
    chk("hold_l", {16'h0, out_l}, {16'h0, wlist[0][15:0]});
    chk("hold_r", {16'h0, out_r}, {16'h0, wlist[0][31:16]});
    pulse();
    chk("next_l", {16'h0, out_l}, {16'h0, wlist[1][15:0]});
    auto_rdy = 1'b0;
    ready = 1'b0;
    pulse();
    for (int i = 0; i < 10 && !req; i++) clk1();
    chk("req_wait", {31'h0, req}, 32'h1);
    i_reset = 1'b1;
    clk1();
    chk("rst_req2", {31'h0, req}, 32'h0);
    chk("rst_busy2", {31'h0, busy}, 32'h0);
    i_reset = 1'b0;
    auto_rdy = 1'b1;
    repeat (5) clk1();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
